// File: rtl/trap_ctrl.sv
// Fixed-priority trap/interrupt sequencer with a nested stack of saved PCs/causes.
// Build option: TRAP_NEST_EN enables NEST_DEPTH-deep nesting; otherwise a single entry.
module trap_ctrl #(
  parameter int NUM_IRQ    = 4,
  parameter int NEST_DEPTH = 2,
`ifdef TRAP_NEST_EN
  parameter int DW         = $clog2(NEST_DEPTH+1)
`else
  parameter int DW         = 1
`endif
) (
  input  logic               clk,
  input  logic               Rst_n,
  input  logic               ecall,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  input  logic               trap_ret,
  input  logic               pipe_rdy,
  input  logic [31:0]        pc,
  input  logic [31:0]        mtvec,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [31:0]        redirect_pc,
  output logic               trapping,
  output logic [DW-1:0]      depth,
  output logic [31:0]        mepc,
  output logic [31:0]        mcause,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               nest_ovf
);

`ifdef TRAP_NEST_EN
  localparam int ND = NEST_DEPTH;
  logic unused;
  assign unused = mtvec[1];
`else
  localparam int ND = 1;
  logic unused;
  assign unused = ^{mtvec[1], NEST_DEPTH[0]};
`endif

  typedef enum logic [1:0] {S_RUN, S_ENTER, S_RETURN} state_t;
  state_t st, st_nxt;

  // cause stored as {is_irq, code[4:0]}
  logic [31:0]        stk_pc    [ND];
  logic [5:0]         stk_cause [ND];
  logic [31:0]        lat_pc, lat_tgt;
  logic [5:0]         lat_cause;
  logic [NUM_IRQ-1:0] lat_ack;

  logic        irq_hit, room, take, ovf_set, do_push, do_pop;
  logic [3:0]  irq_idx;
  logic [4:0]  irq_code;
  logic [31:0] base, top_pc, below_pc;
  logic [5:0]  below_cause;
  int          lim;

  // Preemption limit: only lines below the active irq index may nest; an active ecall blocks all.
  always_comb begin
    lim = NUM_IRQ;
    if (depth != '0) lim = mcause[31] ? int'(mcause[4:0]) - 16 : 0;
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (irq[i] && irq_en[i] && gie && i < lim) begin
        irq_hit = 1'b1;
        irq_idx = 4'(i);
      end
  end

  assign room     = int'(depth) < ND;
  assign irq_code = 5'd16 + {1'b0, irq_idx};
  assign base     = {mtvec[31:2], 2'b00};

  always_comb begin
    top_pc      = '0;
    below_pc    = '0;
    below_cause = '0;
    for (int i = 0; i < ND; i++) begin
      if (i == int'(depth) - 1) top_pc = stk_pc[i];
      if (i == int'(depth) - 2) begin
        below_pc    = stk_pc[i];
        below_cause = stk_cause[i];
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) st <= S_RUN;
    else        st <= st_nxt;

  always_comb begin
    st_nxt  = st;
    take    = 1'b0;
    ovf_set = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    case (st)
      S_RUN:
        if (trap_ret && depth != '0) st_nxt = S_RETURN;
        else if (ecall) begin
          if (room) begin take = 1'b1; st_nxt = S_ENTER; end
          else ovf_set = 1'b1;
        end else if (irq_hit && room) begin
          take   = 1'b1;
          st_nxt = S_ENTER;
        end
      S_ENTER:  if (pipe_rdy) begin do_push = 1'b1; st_nxt = S_RUN; end
      S_RETURN: if (pipe_rdy) begin do_pop  = 1'b1; st_nxt = S_RUN; end
      default:  st_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      trigger_trap     <= 1'b0;
      trigger_trap_ret <= 1'b0;
      redirect_pc      <= '0;
      trapping         <= 1'b0;
      depth            <= '0;
      mepc             <= '0;
      mcause           <= '0;
      irq_ack          <= '0;
      nest_ovf         <= 1'b0;
      lat_pc           <= '0;
      lat_tgt          <= '0;
      lat_cause        <= '0;
      lat_ack          <= '0;
      for (int i = 0; i < ND; i++) begin
        stk_pc[i]    <= '0;
        stk_cause[i] <= '0;
      end
    end else begin
      trigger_trap     <= 1'b0;
      trigger_trap_ret <= 1'b0;
      irq_ack          <= '0;
      if (ovf_set) nest_ovf <= 1'b1;
      // Everything the entry needs is frozen here; later input changes are ignored.
      if (take) begin
        lat_pc <= pc;
        if (ecall) begin
          lat_cause <= {1'b0, 5'd11};
          lat_tgt   <= base;
          lat_ack   <= '0;
        end else begin
          lat_cause <= {1'b1, irq_code};
          lat_tgt   <= mtvec[0] ? base + {25'b0, irq_code, 2'b00} : base;
          lat_ack   <= NUM_IRQ'(1) << irq_idx;
        end
      end
      if (do_push) begin
        for (int i = 0; i < ND; i++)
          if (i == int'(depth)) begin
            stk_pc[i]    <= lat_pc;
            stk_cause[i] <= lat_cause;
          end
        depth        <= depth + DW'(1);
        trapping     <= 1'b1;
        trigger_trap <= 1'b1;
        redirect_pc  <= lat_tgt;
        irq_ack      <= lat_ack;
        mepc         <= lat_pc;
        mcause       <= {lat_cause[5], 26'b0, lat_cause[4:0]};
      end
      if (do_pop) begin
        depth            <= depth - DW'(1);
        trapping         <= depth != DW'(1);
        trigger_trap_ret <= 1'b1;
        redirect_pc      <= top_pc;
        mepc             <= below_pc;
        mcause           <= {below_cause[5], 26'b0, below_cause[4:0]};
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl; expectations are hand-computed constants.
module tb_trap_ctrl;
  localparam int NUM_IRQ = 4;
`ifdef TRAP_NEST_EN
  localparam int ND = 2;
  localparam int DW = 2;
`else
  localparam int ND = 1;
  localparam int DW = 1;
`endif

  logic               clk = 1'b0;
  logic               Rst_n;
  logic               ecall, gie, trap_ret, pipe_rdy;
  logic [NUM_IRQ-1:0] irq, irq_en, irq_ack;
  logic [31:0]        pc, mtvec, redirect_pc, mepc, mcause;
  logic               trigger_trap, trigger_trap_ret, trapping, nest_ovf;
  logic [DW-1:0]      depth;

  int n_chk = 0;
  int n_err = 0;

  trap_ctrl #(.NUM_IRQ(NUM_IRQ), .NEST_DEPTH(2)) dut (
    .clk(clk), .Rst_n(Rst_n), .ecall(ecall), .irq(irq), .irq_en(irq_en), .gie(gie),
    .trap_ret(trap_ret), .pipe_rdy(pipe_rdy), .pc(pc), .mtvec(mtvec),
    .trigger_trap(trigger_trap), .trigger_trap_ret(trigger_trap_ret),
    .redirect_pc(redirect_pc), .trapping(trapping), .depth(depth), .mepc(mepc),
    .mcause(mcause), .irq_ack(irq_ack), .nest_ovf(nest_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Request for one sample, then expect a single entry pulse two edges later.
  task automatic do_entry(input logic e, input logic [NUM_IRQ-1:0] lines, input logic [31:0] tgt,
                          input logic [31:0] cause, input logic [NUM_IRQ-1:0] ack,
                          input int dep, input logic [31:0] epc);
    ecall = e; irq = lines;
    tick;
    ecall = 1'b0; irq = '0;
    chk("entry_early", 32'(trigger_trap), 32'd0);
    tick;
    chk("entry_pulse", 32'(trigger_trap), 32'd1);
    chk("entry_tgt", redirect_pc, tgt);
    chk("entry_cause", mcause, cause);
    chk("entry_ack", 32'(irq_ack), 32'(ack));
    chk("entry_depth", 32'(depth), 32'(dep));
    chk("entry_mepc", mepc, epc);
    chk("entry_trapping", 32'(trapping), 32'd1);
    tick;
    chk("entry_single", 32'(trigger_trap), 32'd0);
  endtask

  task automatic do_ret(input logic [31:0] tgt, input int dep, input logic [31:0] epc);
    trap_ret = 1'b1;
    tick;
    trap_ret = 1'b0;
    chk("ret_early", 32'(trigger_trap_ret), 32'd0);
    tick;
    chk("ret_pulse", 32'(trigger_trap_ret), 32'd1);
    chk("ret_tgt", redirect_pc, tgt);
    chk("ret_depth", 32'(depth), 32'(dep));
    chk("ret_mepc", mepc, epc);
    chk("ret_trapping", 32'(trapping), 32'(dep != 0));
    tick;
    chk("ret_single", 32'(trigger_trap_ret), 32'd0);
  endtask

  task automatic hold_off(input logic e, input logic [NUM_IRQ-1:0] lines, input int n, input int dep);
    ecall = e; irq = lines;
    repeat (n) begin
      tick;
      chk("held_off", 32'(trigger_trap), 32'd0);
    end
    ecall = 1'b0; irq = '0;
    tick;
    chk("held_off_late", 32'(trigger_trap), 32'd0);
    chk("held_off_depth", 32'(depth), 32'(dep));
  endtask

  initial begin
    Rst_n = 1'b0; ecall = 1'b0; irq = '0; irq_en = '0; gie = 1'b0; trap_ret = 1'b0;
    pipe_rdy = 1'b1; pc = '0; mtvec = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tt", 32'(trigger_trap), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_ovf", 32'(nest_ovf), 32'd0);
    Rst_n = 1'b1;
    tick;

    // ecall then mret
    pc = 32'h100; mtvec = 32'h2000;
    do_entry(1'b1, '0, 32'h2000, 32'd11, '0, 1, 32'h100);
    do_ret(32'h100, 0, 32'h0);
    chk("ret_mcause_clr", mcause, 32'd0);

    // gie low masks interrupts
    irq_en = '1;
    hold_off(1'b0, 4'b0100, 2, 0);

    // vectored irq[2], higher lines held off, lower line nests when enabled
    gie = 1'b1; mtvec = 32'h2001; pc = 32'h300;
    do_entry(1'b0, 4'b0100, 32'h2048, 32'h8000_0012, 4'b0100, 1, 32'h300);
    pc = 32'h400;
    hold_off(1'b0, 4'b1000, 3, 1);
`ifdef TRAP_NEST_EN
    do_entry(1'b0, 4'b1001, 32'h2040, 32'h8000_0010, 4'b0001, 2, 32'h400);
    do_ret(32'h400, 1, 32'h300);
    chk("nest_mcause_pop", mcause, 32'h8000_0012);
`else
    hold_off(1'b0, 4'b0001, 3, 1);
`endif
    do_ret(32'h300, 0, 32'h0);

    // pipe_rdy low for 5 cycles; pc/mtvec changes after entry must not matter
    mtvec = 32'h3000; pc = 32'h500; pipe_rdy = 1'b0; ecall = 1'b1;
    tick;
    ecall = 1'b0; pc = 32'h999; mtvec = 32'h7770;
    repeat (5) begin
      tick;
      chk("stall_no_pulse", 32'(trigger_trap), 32'd0);
    end
    pipe_rdy = 1'b1;
    tick;
    chk("stall_pulse", 32'(trigger_trap), 32'd1);
    chk("stall_tgt", redirect_pc, 32'h3000);
    chk("stall_mepc", mepc, 32'h500);
    tick;
    chk("stall_single", 32'(trigger_trap), 32'd0);
    do_ret(32'h500, 0, 32'h0);

    // trap_ret and irq[1] together: return wins, then entry
    mtvec = 32'h2000; pc = 32'h600;
    do_entry(1'b1, '0, 32'h2000, 32'd11, '0, 1, 32'h600);
    pc = 32'h640;
    trap_ret = 1'b1; irq = 4'b0010;
    tick;
    trap_ret = 1'b0;
    chk("tie_no_entry", 32'(trigger_trap), 32'd0);
    tick;
    chk("tie_ret_pulse", 32'(trigger_trap_ret), 32'd1);
    chk("tie_ret_tgt", redirect_pc, 32'h600);
    chk("tie_ret_depth", 32'(depth), 32'd0);
    chk("tie_ret_no_tt", 32'(trigger_trap), 32'd0);
    tick;
    chk("tie_enter_wait", 32'(trigger_trap), 32'd0);
    irq = '0;
    tick;
    chk("tie_irq_pulse", 32'(trigger_trap), 32'd1);
    chk("tie_irq_tgt", redirect_pc, 32'h2000);
    chk("tie_irq_cause", mcause, 32'h8000_0011);
    chk("tie_irq_ack", 32'(irq_ack), 32'h2);
    chk("tie_irq_mepc", mepc, 32'h640);
    tick;
    do_ret(32'h640, 0, 32'h0);

    // fill the stack with ecalls, then one more is dropped
    for (int k = 0; k < ND; k++) begin
      pc = 32'h700 + 32'(16 * k);
      do_entry(1'b1, '0, 32'h2000, 32'd11, '0, k + 1, 32'h700 + 32'(16 * k));
    end
    ecall = 1'b1;
    tick;
    ecall = 1'b0;
    chk("ovf_set", 32'(nest_ovf), 32'd1);
    chk("ovf_no_pulse", 32'(trigger_trap), 32'd0);
    tick;
    chk("ovf_no_pulse2", 32'(trigger_trap), 32'd0);
    chk("ovf_depth", 32'(depth), 32'(ND));
    for (int k = ND - 1; k >= 0; k--)
      do_ret(32'h700 + 32'(16 * k), k, (k > 0) ? 32'h700 + 32'(16 * (k - 1)) : 32'h0);
    chk("ovf_sticky", 32'(nest_ovf), 32'd1);

    // asynchronous reset while in S_ENTER
    pc = 32'h800; pipe_rdy = 1'b0; ecall = 1'b1;
    tick;
    ecall = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_tgt", redirect_pc, 32'h0);
    chk("arst_ovf", 32'(nest_ovf), 32'd0);
    chk("arst_depth", 32'(depth), 32'd0);
    chk("arst_mepc", mepc, 32'h0);
    chk("arst_trapping", 32'(trapping), 32'd0);
    #1 Rst_n = 1'b1;
    pipe_rdy = 1'b1;
    repeat (3) begin
      tick;
      chk("arst_no_pulse", 32'(trigger_trap), 32'd0);
    end
    chk("arst_depth_after", 32'(depth), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
